multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Multi-cycle control FSM for the RISC-V core; replaces the single-cycle decode with a sequenced controller so one shared memory and one ALU serve fetch, address generation and execute.
- Sits between the instruction register (supplies `op`) and the datapath muxes/enables.
- The ALU decoder stays separate and consumes `alu_op`.
- Adds I-type ALU and JAL support, a memory-ready handshake, illegal-opcode detection and an instruction-retire pulse.

Parameters:
- ENABLE_ITYPE, 1, 1 = decode op 0010011 (addi etc.); 0 = treat it as illegal.
- ENABLE_JAL, 1, 1 = decode op 1101111; 0 = treat it as illegal.
- MEM_WAIT_EN, 1, 1 = honour `mem_ready`; 0 = `mem_ready` is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  opcode from the instruction register; stable from DECODE until the next FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction/old-PC register enable.
- result_src  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- imm_src  out  2  immediate format.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  unsupported opcode flag.
- instr_done  out  1  instruction-retire pulse.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM, 4-bit encoded state register: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, JAL=10.
- Undefined codes 11–15 go to FETCH on the next edge, with all outputs 0.
- Reset: on a `rst` edge, state <= FETCH.
- While `rst` is high, pc_write, ir_write, mem_write, reg_write, illegal_op and instr_done are forced to 0.
- Mux selects and `state` show their FETCH values during reset.
- Any output not listed for a state below is 0.

State outputs and transitions:
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes branch target). Next state by op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op, or one disabled by a parameter -> FETCH, with illegal_op=1 for this single cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds while !mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - mem_write stays high every cycle until mem_ready.
  - instr_done = mem_ready; goes to FETCH when mem_ready.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1. Goes to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB (writes PC+4 into rd).

imm_src (combinational from op, valid in every state):
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- all others -> 00

Handshake and timing rules:
- With MEM_WAIT_EN=0, mem_ready is treated as 1.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; elsewhere it is ignored.
- An X on op outside DECODE/MEMADR must not change the state.
- Latency with mem_ready=1:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type / I-type: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
  - Each wait cycle adds 1.
- Reset mid-instruction (e.g. during MEMWRITE): mem_write drops in the same cycle `rst` is high, and the next state is FETCH.

Test Plan:
- lw (op=0000011), mem_ready=1: states 0,1,2,3,4,0 → cycle 5 has reg_write=1, result_src=01, instr_done=1; imm_src=00 throughout.
- sw (op=0100011), mem_ready low for 2 cycles in MEMWRITE → mem_write=1 for 3 cycles, instr_done=1 only on the 3rd cycle, reg_write stays 0.
- beq (op=1100011): zero=1 → pc_write=1 in BEQ; zero=0 → pc_write=0; alu_op=01 in both cases.
- Illegal opcode: op=1111111 → illegal_op=1 for exactly one cycle in DECODE, next state FETCH. Same result for op=1101111 with ENABLE_JAL=0.
- jal (op=1101111): DECODE→JAL (pc_write=1, imm_src=11) → ALUWB (reg_write=1) → FETCH.
- rst=1 asserted mid-MEMREAD with mem_ready=0 → all enables 0 that cycle, state=0 the next cycle. FETCH with mem_ready=0 for 3 cycles → ir_write=pc_write=0 throughout.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Multi-cycle main control FSM for the RISC-V core.
// Sequences fetch, decode, address generation, memory access, execute and
// write-back so that one shared memory and one ALU serve every step.
module multicycle_main_fsm #(
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter bit ENABLE_JAL   = 1'b1,
    parameter bit MEM_WAIT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q;
    state_t state_d;
    logic   ready;

    // Memory handshake collapses to "always ready" when waiting is disabled
    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Immediate format decode, valid in every state
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Next-state and per-state control outputs, with reset override last
    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        state      = state_q;

        case (state_q)
            S_FETCH: begin
                adr_src    = 1'b0;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
                state_d    = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ITYPE: begin
                        if (ENABLE_ITYPE) state_d = S_EXEC_I;
                        else              illegal_op = 1'b1;
                    end
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL: begin
                        if (ENABLE_JAL) state_d = S_JAL;
                        else            illegal_op = 1'b1;
                    end
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
                state_d    = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
                mem_write  = 1'b1;
                instr_done = ready;
                state_d    = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset kills every enable in the same cycle and presents FETCH selects
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
            adr_src    = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
            result_src = 2'b10;
            state      = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed self-checking bench for multicycle_main_fsm.
// Outputs are packed as {state, pc_write, adr_src, mem_write, ir_write,
// result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op,
// instr_done} and compared each cycle against hand-written vectors.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst, rst2;
    logic [6:0] op, op2;
    logic       zero;
    logic       mem_ready, mem_ready2;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state;

    logic       pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal_op2, instr_done2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2, alu_op2, imm_src2;
    logic [3:0] state2;

    logic [20:0] v1, v2;

    int checks   = 0;
    int failures = 0;

    multicycle_main_fsm dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .reg_write(reg_write), .illegal_op(illegal_op),
        .instr_done(instr_done), .state(state)
    );

    multicycle_main_fsm #(
        .ENABLE_ITYPE(1'b0),
        .ENABLE_JAL  (1'b0),
        .MEM_WAIT_EN (1'b0)
    ) dut2 (
        .clk(clk), .rst(rst2), .op(op2), .zero(1'b0), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .adr_src(adr_src2), .mem_write(mem_write2),
        .ir_write(ir_write2), .result_src(result_src2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .imm_src(imm_src2),
        .reg_write(reg_write2), .illegal_op(illegal_op2),
        .instr_done(instr_done2), .state(state2)
    );

    assign v1 = {state, pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_op, instr_done};
    assign v2 = {state2, pc_write2, adr_src2, mem_write2, ir_write2, result_src2,
                 alu_src_a2, alu_src_b2, alu_op2, imm_src2, reg_write2, illegal_op2, instr_done2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values, then FETCH stalled on mem_ready=0 for three cycles
    task automatic test_reset();
        logic [20:0] exp [5];
        logic        r [5];
        exp = '{21'b0000_0000_10_00_10_00_00_000, 21'b0000_0000_10_00_10_00_00_000,
                21'b0000_0000_10_00_10_00_00_000, 21'b0000_0000_10_00_10_00_00_000,
                21'b0000_0000_10_00_10_00_00_000};
        r   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = r[i]; op = 7'b0110011; mem_ready = 1'b0; zero = 1'b0;
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL reset[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [20:0] exp [6];
        logic        r [6];
        exp = '{21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_000,
                21'b0010_0000_00_10_01_00_00_000, 21'b0011_0100_00_00_00_00_00_000,
                21'b0100_0000_01_00_00_00_00_101, 21'b0000_0000_10_00_10_00_00_000};
        r   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op = 7'b0000011; mem_ready = r[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL lw[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    // sw with two wait cycles in MEMWRITE; mem_ready low in DECODE/MEMADR is ignored
    task automatic test_sw_wait();
        logic [20:0] exp [7];
        logic        r [7];
        exp = '{21'b0000_1001_10_00_10_00_01_000, 21'b0001_0000_00_01_01_00_01_000,
                21'b0010_0000_00_10_01_00_01_000, 21'b0101_0110_00_00_00_00_01_000,
                21'b0101_0110_00_00_00_00_01_000, 21'b0101_0110_00_00_00_00_01_001,
                21'b0000_0000_10_00_10_00_01_000};
        r   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            op = 7'b0100011; mem_ready = r[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL sw[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [20:0] exp [10];
        logic [6:0]  o [10];
        logic        r [10];
        exp = '{21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_000,
                21'b0110_0000_00_10_00_10_00_000, 21'b1000_0000_00_00_00_00_00_101,
                21'b0000_0000_10_00_10_00_00_000,
                21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_000,
                21'b0111_0000_00_10_01_10_00_000, 21'b1000_0000_00_00_00_00_00_101,
                21'b0000_0000_10_00_10_00_00_000};
        o   = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
        r   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op = o[i]; mem_ready = r[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL alu[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    // beq taken (zero=1) then not taken (zero=0)
    task automatic test_beq();
        logic [20:0] exp [8];
        logic        r [8];
        logic        z [8];
        exp = '{21'b0000_1001_10_00_10_00_10_000, 21'b0001_0000_00_01_01_00_10_000,
                21'b1001_1000_00_10_00_01_10_001, 21'b0000_0000_10_00_10_00_10_000,
                21'b0000_1001_10_00_10_00_10_000, 21'b0001_0000_00_01_01_00_10_000,
                21'b1001_0000_00_10_00_01_10_001, 21'b0000_0000_10_00_10_00_10_000};
        r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        z   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op = 7'b1100011; mem_ready = r[i]; zero = z[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL beq[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [20:0] exp [5];
        logic        r [5];
        exp = '{21'b0000_1001_10_00_10_00_11_000, 21'b0001_0000_00_01_01_00_11_000,
                21'b1010_1000_00_01_10_00_11_000, 21'b1000_0000_00_00_00_00_11_101,
                21'b0000_0000_10_00_10_00_11_000};
        r   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = 7'b1101111; mem_ready = r[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL jal[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [20:0] exp [4];
        logic        r [4];
        exp = '{21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_010,
                21'b0000_0000_10_00_10_00_00_000, 21'b0000_0000_10_00_10_00_00_000};
        r   = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 7'b1111111; mem_ready = r[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL illegal[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    // Reset asserted mid-MEMREAD (stalled) and mid-MEMWRITE (stalled)
    task automatic test_reset_mid();
        logic [20:0] exp [12];
        logic [6:0]  o [12];
        logic        r [12];
        logic        rs [12];
        exp = '{21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_000,
                21'b0010_0000_00_10_01_00_00_000, 21'b0011_0100_00_00_00_00_00_000,
                21'b0000_0000_10_00_10_00_00_000, 21'b0000_0000_10_00_10_00_00_000,
                21'b0000_1001_10_00_10_00_01_000, 21'b0001_0000_00_01_01_00_01_000,
                21'b0010_0000_00_10_01_00_01_000, 21'b0101_0110_00_00_00_00_01_000,
                21'b0000_0000_10_00_10_00_01_000, 21'b0000_0000_10_00_10_00_01_000};
        o   = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011,
                7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011};
        r   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op = o[i]; mem_ready = r[i]; rst = rs[i];
            #1;
            checks++;
            if (v1 !== exp[i]) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%b exp=%b", i, v1, exp[i]);
            end
        end
    endtask

    // Instance with JAL and I-type disabled and mem_ready ignored (held at 0)
    task automatic test_disabled();
        logic [20:0] exp [11];
        logic [6:0]  o [11];
        logic        rs [11];
        exp = '{21'b0000_0000_10_00_10_00_11_000,
                21'b0000_1001_10_00_10_00_11_000, 21'b0001_0000_00_01_01_00_11_010,
                21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_010,
                21'b0000_1001_10_00_10_00_00_000, 21'b0001_0000_00_01_01_00_00_000,
                21'b0010_0000_00_10_01_00_00_000, 21'b0011_0100_00_00_00_00_00_000,
                21'b0100_0000_01_00_00_00_00_101, 21'b0000_1001_10_00_10_00_00_000};
        o   = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b0010011, 7'b0010011,
                7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011};
        rs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            op2 = o[i]; mem_ready2 = 1'b0; rst2 = rs[i];
            #1;
            checks++;
            if (v2 !== exp[i]) begin
                failures++;
                $display("FAIL disabled[%0d] got=%b exp=%b", i, v2, exp[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        op = 7'b0110011; op2 = 7'b0110011;
        zero = 1'b0; mem_ready = 1'b0; mem_ready2 = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_ops();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid();
        test_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
